// File: rtl/nand_avalon_ctrl_if.sv
// Register-bus interface between the system interconnect and nand_avalon_ctrl.
// Latency: rddata is registered, valid the cycle after rd.
// Backpressure: none; the slave accepts every wr/rd strobe (writes while busy are dropped).
//
// Signals:
//   addr   : register select (0 DATA, 1 CMD, 2 STATUS, 3 reserved)
//   wr/rd  : single-cycle write / read strobes
//   wrdata : write data
//   rddata : registered read data
interface nand_avalon_ctrl_if;
  logic [1:0]  addr;
  logic        wr;
  logic        rd;
  logic [31:0] wrdata;
  logic [31:0] rddata;

  modport master (output addr, output wr, output rd, output wrdata, input rddata);
  modport slave  (input addr, input wr, input rd, input wrdata, output rddata);
endinterface

// File: rtl/nand_avalon_ctrl.sv
// Register-driven bridge from a simple MM bus to a raw 8-bit async NAND pin interface.
// Latency: register reads 1 cycle; each op takes T_SETUP + 2*T_STROBE (+1 DONE) cycles, or 1 for CE/unknown.
// Backpressure: none on the bus; starts and register writes arriving while busy are dropped.
//
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   bus (slave)      : addr/wr/rd/wrdata/rddata register port
//   nand_dq          : bidirectional NAND data bus, high-Z unless writing
//   nand_cle/ale     : command / address latch enables
//   nand_nce/nwe/nre : chip enable, write strobe, read strobe (active-low)
//   nand_nwp         : write protect (active-low), software controlled via STATUS bit1
//   nand_rnb         : ready/busy from the flash, low = busy
//   done_irq         : only when DONE_IRQ_EN is defined; level set on entering DONE,
//                      cleared by a STATUS read or the next start
//
// Activation: an op starts when a cycle with wr follows a cycle with rd of CMD.
// The write in that cycle lands first, so writing CMD there selects the opcode run.
module nand_avalon_ctrl #(
  parameter int T_STROBE = 2,
  parameter int T_SETUP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  nand_avalon_ctrl_if.slave bus,
  inout  wire  [7:0]        nand_dq,
  output logic              nand_cle,
  output logic              nand_ale,
  output logic              nand_nce,
  output logic              nand_nwe,
  output logic              nand_nre,
  output logic              nand_nwp,
  input  logic              nand_rnb
`ifdef DONE_IRQ_EN
  ,
  output logic              done_irq
`endif
);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CMD    = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;

  localparam logic [7:0] OP_CMD_LATCH  = 8'h01;
  localparam logic [7:0] OP_ADDR_LATCH = 8'h02;
  localparam logic [7:0] OP_DATA_WRITE = 8'h03;
  localparam logic [7:0] OP_DATA_READ  = 8'h04;
  localparam logic [7:0] OP_WAIT_READY = 8'h05;
  localparam logic [7:0] OP_CE_ON      = 8'h06;
  localparam logic [7:0] OP_CE_OFF     = 8'h07;

  // Phase counters count down from N-1 to 0; 8 bits covers any sane timing.
  localparam logic [7:0] SETUP_LD  = 8'(T_SETUP - 1);
  localparam logic [7:0] STROBE_LD = 8'(T_STROBE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE_LO,
    S_STROBE_HI,
    S_WAIT_RB,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;       // opcode of the op in flight

  logic [7:0]  opcode_q;         // CMD register
  logic [7:0]  tx_q;             // DATA register, write side
  logic [7:0]  rx_q;             // DATA register, read side
  logic        nwp_q;
  logic        done_q;
  logic        rnb_q;            // single flop keeps the ready-to-done latency at 2 cycles
  logic        arm_q;            // previous cycle was a read of CMD
  logic        dq_oe_q;

  logic        busy;
  logic        wr_ok;
  logic        rd_ok;
  logic        start;
  logic        launch;
  logic [7:0]  op_eff;

  logic        xfer_d;
  logic        wr_op_d;
  logic        cle_d, ale_d, nwe_d, nre_d, dq_oe_d;

  logic        unused_wrdata;
  assign unused_wrdata = ^bus.wrdata[31:8];

  // DONE is not busy, so software sees busy=0 and done=1 together.
  assign busy   = (state_q == S_SETUP) || (state_q == S_STROBE_LO) ||
                  (state_q == S_STROBE_HI) || (state_q == S_WAIT_RB);
  assign wr_ok  = bus.wr && !busy;
  assign rd_ok  = bus.rd && !bus.wr;       // a simultaneous wr wins
  assign start  = arm_q && bus.wr;
  assign launch = start && !busy;

  // The activating write may be to CMD; it must select the opcode that runs.
  assign op_eff = (wr_ok && bus.addr == A_CMD) ? bus.wrdata[7:0] : opcode_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (launch) begin
      op_d = op_eff;
      case (op_eff)
        OP_CMD_LATCH, OP_ADDR_LATCH, OP_DATA_WRITE, OP_DATA_READ: begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end
        OP_WAIT_READY: state_d = S_WAIT_RB;
        default:       state_d = S_DONE;
      endcase
    end else begin
      case (state_q)
        S_SETUP: begin
          if (cnt_q == 8'd0) begin
            state_d = S_STROBE_LO;
            cnt_d   = STROBE_LD;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_STROBE_LO: begin
          if (cnt_q == 8'd0) begin
            state_d = S_STROBE_HI;
            cnt_d   = STROBE_LD;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_STROBE_HI: begin
          if (cnt_q == 8'd0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_WAIT_RB: begin
          if (rnb_q) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pin values are decoded from the next state and registered so the
  // NAND sees glitch-free edges aligned to clk.
  always_comb begin
    xfer_d  = (state_d == S_SETUP) || (state_d == S_STROBE_LO) || (state_d == S_STROBE_HI);
    wr_op_d = (op_d == OP_CMD_LATCH) || (op_d == OP_ADDR_LATCH) || (op_d == OP_DATA_WRITE);
    // Latch enables hold through DONE and drop only once back in IDLE.
    cle_d   = (op_d == OP_CMD_LATCH)  && (xfer_d || state_d == S_DONE);
    ale_d   = (op_d == OP_ADDR_LATCH) && (xfer_d || state_d == S_DONE);
    nwe_d   = !((state_d == S_STROBE_LO) && wr_op_d);
    nre_d   = !((state_d == S_STROBE_LO) && (op_d == OP_DATA_READ));
    dq_oe_d = xfer_d && wr_op_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nand_cle <= 1'b0;
      nand_ale <= 1'b0;
      nand_nwe <= 1'b1;
      nand_nre <= 1'b1;
      nand_nce <= 1'b1;
      dq_oe_q  <= 1'b0;
    end else begin
      nand_cle <= cle_d;
      nand_ale <= ale_d;
      nand_nwe <= nwe_d;
      nand_nre <= nre_d;
      dq_oe_q  <= dq_oe_d;
      if (launch && op_eff == OP_CE_ON)  nand_nce <= 1'b0;
      if (launch && op_eff == OP_CE_OFF) nand_nce <= 1'b1;
    end
  end

  // tx_q cannot change while busy, so it is stable for the whole drive window.
  assign nand_dq  = dq_oe_q ? tx_q : 8'hzz;
  assign nand_nwp = nwp_q;

  // ---------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode_q   <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      nwp_q      <= 1'b0;
      done_q     <= 1'b0;
      rnb_q      <= 1'b0;
      arm_q      <= 1'b0;
      bus.rddata <= '0;
    end else begin
      rnb_q <= nand_rnb;
      arm_q <= bus.rd && (bus.addr == A_CMD);

      if (wr_ok) begin
        case (bus.addr)
          A_DATA:   tx_q     <= bus.wrdata[7:0];
          A_CMD:    opcode_q <= bus.wrdata[7:0];
          A_STATUS: nwp_q    <= bus.wrdata[1];
          default:  ;
        endcase
      end

      // Sample on the last low cycle, when the flash output is settled.
      if (state_q == S_STROBE_LO && cnt_q == 8'd0 && op_q == OP_DATA_READ)
        rx_q <= nand_dq;

      if (state_d == S_DONE)
        done_q <= 1'b1;
      else if (launch)
        done_q <= 1'b0;

      if (rd_ok) begin
        case (bus.addr)
          A_DATA:   bus.rddata <= {24'h0, rx_q};
          A_CMD:    bus.rddata <= {24'h0, opcode_q};
          A_STATUS: bus.rddata <= {28'h0, done_q, rnb_q, nwp_q, busy};
          default:  bus.rddata <= '0;
        endcase
      end
    end
  end

`ifdef DONE_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_irq <= 1'b0;
    end else if (state_d == S_DONE) begin
      done_irq <= 1'b1;
    end else if (launch || (rd_ok && bus.addr == A_STATUS)) begin
      done_irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_nand_avalon_ctrl.sv
// Self-checking bench for nand_avalon_ctrl: scoreboarded register reads and NAND strobes.
// Stimulus drives on negedge; read monitor checks rddata 1ns after the sampling posedge.
// Strobe monitor measures every nWE/nRE low pulse and checks it against the expected queue.
module tb_nand_avalon_ctrl;
  localparam int TS  = 2;
  localparam int TSU = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       nand_cle, nand_ale, nand_nce, nand_nwe, nand_nre, nand_nwp;
  logic       nand_rnb;
  wire  [7:0] nand_dq;
  logic       drv_en;
  logic [7:0] drv_val;
`ifdef DONE_IRQ_EN
  logic       done_irq;
`endif

  nand_avalon_ctrl_if bus ();

  assign nand_dq = drv_en ? drv_val : 8'hzz;

  nand_avalon_ctrl #(.T_STROBE(TS), .T_SETUP(TSU)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .nand_dq  (nand_dq),
    .nand_cle (nand_cle),
    .nand_ale (nand_ale),
    .nand_nce (nand_nce),
    .nand_nwe (nand_nwe),
    .nand_nre (nand_nre),
    .nand_nwp (nand_nwp),
    .nand_rnb (nand_rnb)
`ifdef DONE_IRQ_EN
    ,
    .done_irq (done_irq)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (register-level view of the block).
  logic [7:0] m_tx, m_op, m_rx;
  bit         m_nwp, m_nce;

  typedef struct {
    bit         is_read;
    int         width;
    bit         cle;
    bit         ale;
    logic [7:0] dq;
  } strobe_t;

  strobe_t     st_q[$];
  logic [31:0] rd_exp[$];
  string       rd_name[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] st(input bit d, input bit b);
    return {28'h0, d, nand_rnb, m_nwp, b};
  endfunction

  task automatic model_reset();
    m_tx = 8'h0; m_op = 8'h0; m_rx = 8'h0; m_nwp = 1'b0; m_nce = 1'b1;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd0: m_tx = d[7:0];
      2'd1: m_op = d[7:0];
      2'd2: m_nwp = d[1];
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    rd_exp.push_back(exp);
    rd_name.push_back(name);
    bus.addr = a; bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d, input bit apply);
    if (apply) model_write(a, d);
    bus.addr = a; bus.wrdata = d; bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  function automatic strobe_t mk_strobe(input logic [7:0] op, input int w);
    strobe_t s;
    s.is_read = (op == 8'h04);
    s.width   = w;
    s.cle     = (op == 8'h01);
    s.ale     = (op == 8'h02);
    s.dq      = m_tx;
    return s;
  endfunction

  // Arm (read CMD), activate with a write to wa, and check status mid-op and at the end.
  task automatic run_op(input logic [1:0] wa, input logic [31:0] wd, input logic [7:0] rv);
    bit lng;
    do_read(2'd1, {24'h0, m_op}, "cmd_arm");
    model_write(wa, wd);
    if (m_op >= 8'h01 && m_op <= 8'h04) st_q.push_back(mk_strobe(m_op, TS));
    if (m_op == 8'h04) begin drv_val = rv; drv_en = 1'b1; m_rx = rv; end
    lng = (m_op >= 8'h01 && m_op <= 8'h05);
    do_write(wa, wd, 1'b0);
    do_read(2'd2, st(!lng, lng), "status_during_op");
    idle(TSU + 2*TS + 4);
    if (m_op == 8'h06) m_nce = 1'b0;
    else if (m_op == 8'h07) m_nce = 1'b1;
    do_read(2'd2, st(1'b1, 1'b0), "status_after_op");
    drv_en = 1'b0;
    chk("nce_pin", {31'h0, nand_nce}, {31'h0, m_nce});
  endtask

  function automatic logic [7:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 8'(r + 1);
    if (r == 7) return 8'h00;
    return 8'($urandom_range(8, 255));
  endfunction

  // Read scoreboard monitor.
  initial begin
    forever begin
      @(posedge clk);
      if (rst && bus.rd && !bus.wr) begin
        #1;
        if (rd_exp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL read_unexpected: got 0x%0h, expected no read", bus.rddata);
        end else begin
          chk(rd_name.pop_front(), bus.rddata, rd_exp.pop_front());
        end
      end
    end
  end

  // Strobe monitor: measures nWE/nRE low pulses in cycles.
  initial begin
    int lo = 0;
    bit c_rd, c_cle, c_ale;
    logic [7:0] c_dq;
    strobe_t e;
    forever begin
      @(negedge clk);
      if (!nand_nwe || !nand_nre) begin
        if (lo == 0) begin
          c_rd = !nand_nre; c_cle = nand_cle; c_ale = nand_ale; c_dq = nand_dq;
        end
        lo++;
      end else if (lo != 0) begin
        if (st_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL strobe_unexpected: got a %0d-cycle pulse, expected none", lo);
        end else begin
          e = st_q.pop_front();
          chk("strobe_kind",  {31'h0, c_rd},  {31'h0, e.is_read});
          chk("strobe_width", lo,             e.width);
          chk("strobe_cle",   {31'h0, c_cle}, {31'h0, e.cle});
          chk("strobe_ale",   {31'h0, c_ale}, {31'h0, e.ale});
          if (!e.is_read) chk("strobe_dq", {24'h0, c_dq}, {24'h0, e.dq});
        end
        lo = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  tx, op;
    logic [1:0]  wa;
    logic [31:0] wd;
    int          r;

    rst = 1'b0; bus.addr = '0; bus.wr = 1'b0; bus.rd = 1'b0; bus.wrdata = '0;
    nand_rnb = 1'b1; drv_en = 1'b0; drv_val = 8'h0;
    model_reset();
    idle(2);
    rst = 1'b1;

    // Reset state
    chk("rst_nce", {31'h0, nand_nce}, 32'd1);
    chk("rst_nwe", {31'h0, nand_nwe}, 32'd1);
    chk("rst_nre", {31'h0, nand_nre}, 32'd1);
    chk("rst_cle", {31'h0, nand_cle}, 32'd0);
    chk("rst_ale", {31'h0, nand_ale}, 32'd0);
    chk("rst_nwp", {31'h0, nand_nwp}, 32'd0);
    idle(1);
    do_read(2'd2, 32'h4, "status_rst");
    do_read(2'd0, 32'h0, "data_rst");
    do_read(2'd1, 32'h0, "cmd_rst");
    idle(1);

    // CMD write alone never starts an op
    do_write(2'd1, 32'h02, 1'b1);
    idle(1);
    do_read(2'd1, 32'h02, "cmd_only_readback");
    idle(1);
    do_read(2'd2, st(1'b0, 1'b0), "cmd_only_not_busy");
    idle(20);
    chk("cmd_only_ale", {31'h0, nand_ale}, 32'd0);

    // CMD_LATCH 0x90
    do_write(2'd0, 32'h90, 1'b1);
    do_write(2'd1, 32'h01, 1'b1);
    run_op(2'd3, 32'h0, 8'h0);

    // DATA_READ with the flash presenting 0xA5
    do_write(2'd1, 32'h04, 1'b1);
    run_op(2'd3, 32'h0, 8'hA5);
    do_read(2'd0, 32'hA5, "data_read_a5");
    idle(1);

    // WAIT_READY with rnb low for 10 cycles
    nand_rnb = 1'b0;
    idle(2);
    do_write(2'd1, 32'h05, 1'b1);
    do_read(2'd1, 32'h05, "cmd_arm_wait");
    do_write(2'd3, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) do_read(2'd2, st(1'b0, 1'b1), "wait_busy");
    nand_rnb = 1'b1;
    idle(2);
    do_read(2'd2, st(1'b1, 1'b0), "wait_done_2cyc");

    // Start and register writes while busy are ignored
    do_write(2'd0, 32'h3C, 1'b1);
    do_write(2'd1, 32'h01, 1'b1);
    st_q.push_back(mk_strobe(8'h01, TS));
    do_read(2'd1, 32'h01, "cmd_arm_guard");
    do_write(2'd3, 32'h0, 1'b0);
    do_read(2'd1, 32'h01, "cmd_rd_busy");
    do_write(2'd1, 32'h07, 1'b0);
    do_write(2'd0, 32'hFF, 1'b0);
    idle(8);
    do_read(2'd1, 32'h01, "cmd_after_busy");
    idle(1);
    run_op(2'd3, 32'h0, 8'h0);

    // Reset in the middle of the low strobe
    do_write(2'd0, 32'h5A, 1'b1);
    do_write(2'd1, 32'h01, 1'b1);
    st_q.push_back(mk_strobe(8'h01, 1));
    do_read(2'd1, 32'h01, "cmd_arm_abort");
    do_write(2'd3, 32'h0, 1'b0);
    for (int i = 0; i < 20 && nand_nwe; i++) @(negedge clk);
    chk("abort_reached_strobe", {31'h0, nand_nwe}, 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("abort_nwe", {31'h0, nand_nwe}, 32'd1);
    chk("abort_cle", {31'h0, nand_cle}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle(1);
    do_read(2'd2, st(1'b0, 1'b0), "abort_status_idle");
    do_read(2'd1, 32'h0, "abort_cmd_cleared");
    idle(1);

    // Randomized operations
    for (int it = 0; it < 30; it++) begin
      tx = 8'($urandom);
      op = rand_op();
      do_write(2'd0, {24'h0, tx}, 1'b1);
      do_write(2'd1, {24'h0, op}, 1'b1);
      if ($urandom_range(0, 3) == 0) do_write(2'd2, {30'h0, 1'($urandom), 1'b0}, 1'b1);
      r = $urandom_range(0, 3);
      if (r == 0) begin wa = 2'd1; wd = {24'h0, rand_op()}; end
      else if (r == 1) begin wa = 2'd0; wd = $urandom; end
      else begin wa = 2'd3; wd = $urandom; end
      run_op(wa, wd, 8'($urandom));
      chk("nwp_pin", {31'h0, nand_nwp}, {31'h0, m_nwp});
      do_read(2'd0, {24'h0, m_rx}, "data_rd");
      do_read(2'd1, {24'h0, m_op}, "cmd_rd");
      idle(1);
    end

    idle(5);
    chk("strobes_outstanding", st_q.size(), 0);
    chk("reads_outstanding", rd_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
